fetch_word_splitter: RTL and testbench

Fetch-side consumer sitting directly downstream of the one-deep fetch data buffer. It pops tagged 64-bit fetch words ({word address, two instructions}) from the buffer's read port. It splits each word into two 32-bit instructions and presents them one at a time, with their PC, to decode over a valid/ready handshake. On a redirect (flush) it reloads its expected PC and silently discards every stale buffered word whose address does not match.

---
 rtl/fetch_word_splitter.sv | 94 +++++++++
 tb/tb_fetch_word_splitter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_word_splitter.sv
// Splits tagged 64-bit fetch words into two 32-bit instructions with PCs for decode.
// Words whose address does not match the expected PC (stale after a redirect) are dropped and counted.
module fetch_word_splitter #(
  parameter int unsigned    AddrWidth = 64,
  parameter int unsigned    WordWidth = 64,
  parameter int unsigned    InstWidth = 32,
  parameter logic [AddrWidth-1:0] ResetPc = 64'h8000_0000
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [AddrWidth+WordWidth-1:0] i_buf_rdata,
  input  logic                           i_buf_rempty,
  output logic                           o_buf_rinc,
  input  logic                           i_flush_valid,
  input  logic [AddrWidth-1:0]           i_flush_pc,
  output logic                           o_inst_valid,
  input  logic                           i_inst_ready,
  output logic [InstWidth-1:0]           o_inst,
  output logic [AddrWidth-1:0]           o_inst_pc,
  output logic [15:0]                    o_drop_cnt
);

  typedef enum logic [1:0] {ST_EMPTY, ST_SLOT0, ST_SLOT1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [WordWidth-1:0]   r_hold, w_hold_nxt;
  logic [AddrWidth-1:0]   r_next_pc, w_next_pc_nxt;
  logic [15:0]            r_drop_cnt, w_drop_cnt_nxt;

  logic                   w_fire;
  logic                   w_drain;
  logic                   w_match;
  logic [AddrWidth-1:0]   w_pc_adv;
  logic [AddrWidth-1:0]   w_buf_addr;
  logic [WordWidth-1:0]   w_buf_word;

  assign w_buf_addr   = i_buf_rdata[AddrWidth+WordWidth-1:WordWidth];
  assign w_buf_word   = i_buf_rdata[WordWidth-1:0];

  assign o_inst_valid = (r_state != ST_EMPTY) && !i_flush_valid;
  assign w_fire       = o_inst_valid && i_inst_ready;
  assign w_drain      = (r_state == ST_EMPTY) || ((r_state == ST_SLOT1) && w_fire);
  assign o_buf_rinc   = w_drain && !i_buf_rempty && !i_flush_valid && i_rst_n;

  assign o_inst       = (r_state == ST_SLOT1) ? r_hold[2*InstWidth-1:InstWidth]
                                              : r_hold[InstWidth-1:0];
  assign o_inst_pc    = r_next_pc;
  assign o_drop_cnt   = r_drop_cnt;

  // A pop in the same cycle as a SLOT1 fire is matched against the already-advanced PC.
  assign w_pc_adv     = w_fire ? r_next_pc + AddrWidth'(4) : r_next_pc;
  assign w_match      = (w_buf_addr == (w_pc_adv & ~AddrWidth'(7)));

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_next_pc_nxt  = w_pc_adv;
    w_drop_cnt_nxt = r_drop_cnt;
    if (i_flush_valid) begin
      w_state_nxt   = ST_EMPTY;
      w_next_pc_nxt = i_flush_pc & ~AddrWidth'(3);
    end else begin
      if (w_fire) begin
        w_state_nxt = (r_state == ST_SLOT0) ? ST_SLOT1 : ST_EMPTY;
      end
      if (o_buf_rinc) begin
        if (w_match) begin
          w_hold_nxt  = w_buf_word;
          w_state_nxt = w_pc_adv[2] ? ST_SLOT1 : ST_SLOT0;
        end else begin
          w_state_nxt = ST_EMPTY;
          if (r_drop_cnt != 16'hFFFF) begin
            w_drop_cnt_nxt = r_drop_cnt + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_EMPTY;
      r_hold     <= '0;
      r_next_pc  <= ResetPc;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_next_pc  <= w_next_pc_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_word_splitter.sv
// Directed bench for fetch_word_splitter: a small queue stands in for the upstream fetch buffer.
module tb_fetch_word_splitter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [127:0]  buf_rdata;
  logic          buf_rempty;
  logic          buf_rinc;
  logic          flush_valid;
  logic [63:0]   flush_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [63:0]   inst_pc;
  logic [15:0]   drop_cnt;

  int            errors = 0;
  int            checks = 0;
  int            pops   = 0;
  logic [127:0]  q[$];
  bit            stream = 1'b0;

  always #5 clk = ~clk;

  fetch_word_splitter dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_buf_rdata   (buf_rdata),
    .i_buf_rempty  (buf_rempty),
    .o_buf_rinc    (buf_rinc),
    .i_flush_valid (flush_valid),
    .i_flush_pc    (flush_pc),
    .o_inst_valid  (inst_valid),
    .i_inst_ready  (inst_ready),
    .o_inst        (inst),
    .o_inst_pc     (inst_pc),
    .o_drop_cnt    (drop_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word at address a carries instructions {C0DE, pc[15:0]} for pc=a and pc=a+4.
  function automatic logic [127:0] mkword(input logic [63:0] a);
    logic [63:0] b;
    b = a + 64'd4;
    return {a, 16'hC0DE, b[15:0], 16'hC0DE, a[15:0]};
  endfunction

  task automatic set_buf();
    if (stream) begin
      buf_rempty = 1'b0;
      buf_rdata  = '0;
    end else if (q.size() > 0) begin
      buf_rempty = 1'b0;
      buf_rdata  = q[0];
    end else begin
      buf_rempty = 1'b1;
      buf_rdata  = '0;
    end
  endtask

  task automatic tick();
    logic popped;
    popped = buf_rinc;
    @(posedge clk);
    if (popped) begin
      pops++;
      if (!stream && q.size() > 0) void'(q.pop_front());
    end
    @(negedge clk);
    set_buf();
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] pc);
    logic [15:0] lo;
    lo = pc[15:0];
    chk({tag, ".valid"}, inst_valid, v);
    chk({tag, ".pc"}, inst_pc, pc);
    if (v) chk({tag, ".inst"}, inst, {16'hC0DE, lo});
  endtask

  initial begin
    rst_n       = 1'b0;
    flush_valid = 1'b0;
    flush_pc    = '0;
    inst_ready  = 1'b1;
    set_buf();
    #12;
    chk("rst.valid", inst_valid, 1'b0);
    chk("rst.inst", inst, 32'h0);
    chk("rst.pc", inst_pc, 64'h8000_0000);
    chk("rst.rinc", buf_rinc, 1'b0);
    chk("rst.drop", drop_cnt, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First word: literal test vector
    q.push_back({64'h8000_0000, 64'h2222_2222_1111_1111});
    set_buf();
    #1;
    chk("t1.rinc_empty", buf_rinc, 1'b1);
    chk("t1.valid_pre", inst_valid, 1'b0);
    tick();
    chk("t1.s0.valid", inst_valid, 1'b1);
    chk("t1.s0.inst", inst, 32'h1111_1111);
    chk("t1.s0.pc", inst_pc, 64'h8000_0000);
    chk("t1.s0.rinc", buf_rinc, 1'b0);
    tick();
    chk("t1.s1.valid", inst_valid, 1'b1);
    chk("t1.s1.inst", inst, 32'h2222_2222);
    chk("t1.s1.pc", inst_pc, 64'h8000_0004);
    chk("t1.s1.rinc", buf_rinc, 1'b0);
    tick();
    chk("t1.done.valid", inst_valid, 1'b0);
    chk("t1.done.pc", inst_pc, 64'h8000_0008);
    chk("t1.pops", pops, 1);

    // Three back-to-back words, six instructions without a bubble
    q.push_back(mkword(64'h8000_0008));
    q.push_back(mkword(64'h8000_0010));
    q.push_back(mkword(64'h8000_0018));
    set_buf();
    #1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk_out($sformatf("t2.i%0d", i), 1'b1, 64'h8000_0008 + 64'(4 * i));
      tick();
    end
    chk_out("t2.end", 1'b0, 64'h8000_0020);
    chk("t2.pops", pops, 4);

    // Back-pressure in SLOT1 with a word waiting
    q.push_back(mkword(64'h8000_0020));
    q.push_back(mkword(64'h8000_0028));
    set_buf();
    #1;
    tick();
    chk_out("t3.s0", 1'b1, 64'h8000_0020);
    tick();
    inst_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("t3.stall%0d", i), 1'b1, 64'h8000_0024);
      chk($sformatf("t3.stall%0d.rinc", i), buf_rinc, 1'b0);
      tick();
    end
    inst_ready = 1'b1;
    #1;
    chk("t3.release.rinc", buf_rinc, 1'b1);
    tick();
    chk_out("t3.next", 1'b1, 64'h8000_0028);
    tick();
    chk_out("t3.s1", 1'b1, 64'h8000_002C);

    // Flush in a SLOT1 fire cycle while a stale word waits upstream
    q.push_back(mkword(64'h8000_0030));
    set_buf();
    flush_valid = 1'b1;
    flush_pc    = 64'h8000_0107;
    #1;
    chk("t4.flush.valid", inst_valid, 1'b0);
    chk("t4.flush.rinc", buf_rinc, 1'b0);
    tick();
    flush_valid = 1'b0;
    #1;
    chk_out("t4.after", 1'b0, 64'h8000_0104);
    chk("t4.drop0", drop_cnt, 16'd0);
    chk("t4.stale.rinc", buf_rinc, 1'b1);
    tick();
    chk("t4.drop1", drop_cnt, 16'd1);
    chk("t4.valid_after_drop", inst_valid, 1'b0);
    q.push_back(mkword(64'h8000_0100));
    set_buf();
    #1;
    chk("t4.good.rinc", buf_rinc, 1'b1);
    tick();
    chk_out("t4.slot1", 1'b1, 64'h8000_0104);
    chk("t4.drop_hold", drop_cnt, 16'd1);
    inst_ready = 1'b0;
    #1;

    // Stream mismatched words until the drop counter saturates
    stream = 1'b1;
    flush_valid = 1'b1;
    flush_pc    = 64'h8000_0108;
    tick();
    flush_valid = 1'b0;
    #1;
    chk("t5.flush_nodrop", drop_cnt, 16'd1);
    repeat (65533) tick();
    chk("t5.fffe", drop_cnt, 16'hFFFE);
    tick();
    chk("t5.ffff", drop_cnt, 16'hFFFF);
    repeat (6) tick();
    chk("t5.sat", drop_cnt, 16'hFFFF);
    chk("t5.valid", inst_valid, 1'b0);
    chk("t5.pc", inst_pc, 64'h8000_0108);

    // Asynchronous reset away from any clock edge
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6.valid", inst_valid, 1'b0);
    chk("t6.inst", inst, 32'h0);
    chk("t6.pc", inst_pc, 64'h8000_0000);
    chk("t6.drop", drop_cnt, 16'h0);
    chk("t6.rinc", buf_rinc, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
